// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings and FSM states.
// No logic lives here.
// Imported by data_mem_responder.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW     = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/sram_1rw.sv
// Single-port word SRAM with a registered read port.
// Latency: read data valid the cycle after an enabled read; writes land at the edge.
// No backpressure: every enabled access completes in one cycle.
module sram_1rw #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the RV32I data port, backed by a word-organised SRAM.
// Latency: SW and errors respond 1 cycle after accept; loads and SB/SH after 2.
// Backpressure: req_ready is high only in IDLE; responses cannot be stalled.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    typedef struct packed {
        logic                  write;
        logic [2:0]            funct3;
        logic [1:0]            off;
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           wdata;
    } req_t;

    state_t                state, state_n;
    req_t                  lat;
    logic                  accept;
    logic                  illegal;
    logic                  sram_en, sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_wdata, sram_rdata;
    logic                  unused_addr_hi;

    // Upper address bits alias by design.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3, misal;
        bad_f3 = wr ? !(f3 inside {F3_B, F3_H, F3_W})
                    : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misal  = ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
        return bad_f3 || misal;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'h0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] mask, data;
        if (f3 == F3_B) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {4{wd[7:0]}};
        end else begin
            mask = 32'h0000_FFFF << {off, 3'b000};
            data = {2{wd[15:0]}};
        end
        return (w & ~mask) | (data & mask);
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign illegal    = is_illegal(req_write, req_funct3, req_addr[1:0]);

    always_comb begin
        state_n    = state;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = lat.idx;
        sram_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_n = RESP;
                    end else begin
                        sram_en   = 1'b1;
                        sram_addr = req_addr[ADDR_WIDTH+1:2];
                        if (req_write && req_funct3 == F3_W) begin
                            sram_we    = 1'b1;
                            sram_wdata = req_wdata;
                            state_n    = RESP;
                        end else begin
                            state_n = req_write ? RMW : RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: state_n = RESP;
            RMW: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_wdata = store_merge(sram_rdata, lat.wdata, lat.funct3, lat.off);
                state_n    = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else begin
            state <= state_n;
            // Response fields change only on the edge that enters RESP.
            if (accept && (illegal || (req_write && req_funct3 == F3_W))) begin
                resp_rdata <= 32'h0;
                resp_error <= illegal;
            end else if (state == RD_WAIT) begin
                resp_rdata <= load_extend(sram_rdata, lat.funct3, lat.off);
                resp_error <= 1'b0;
            end else if (state == RMW) begin
                resp_rdata <= 32'h0;
                resp_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lat <= '{write:  req_write,
                     funct3: req_funct3,
                     off:    req_addr[1:0],
                     idx:    req_addr[ADDR_WIDTH+1:2],
                     wdata:  req_wdata};
        end
    end

    sram_1rw #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
        .clock (clock),
        .en    (sram_en),
        .we    (sram_we && !reset),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder: table of requests plus
// hand-written reset-abort and busy-request sequences.
module tb_data_mem_responder;

    localparam int AW = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    typedef struct {
        string       name;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and check response timing and contents.
    task automatic do_req(input vec_t v);
        int  n;
        bit  got;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        chk({v.name, " ready"}, {31'h0, req_ready}, 32'h1);
        tick();
        req_valid  = 1'b0;
        req_write  = ~v.wr;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        got = 1'b0;
        n   = 0;
        while (!got && n < 6) begin
            if (resp_valid) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk({v.name, " latency"}, got ? n : -1, v.lat);
        if (got) begin
            chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
            chk({v.name, " error"}, {31'h0, resp_error}, {31'h0, v.exp_err});
            tick();
            chk({v.name, " pulse"}, {31'h0, resp_valid}, 32'h0);
        end
    endtask

    task automatic add(input string nm, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input bit ee, input int lat);
        vec_t v;
        v.name = nm; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        int   seen;

        add("sw10",    1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
        add("lw10",    0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
        add("lb13",    0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1);
        add("lbu13",   0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 1);
        add("lh12",    0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1);
        add("lhu10",   0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 1);
        add("sb11",    1, 3'b000, 32'h11, 32'h12345677, 32'h0,        0, 1);
        add("lw10b",   0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 1);
        add("sh12",    1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0,        0, 1);
        add("lw10c",   0, 3'b010, 32'h10, 32'h0,        32'hCAFE77EF, 0, 1);
        add("sw00",    1, 3'b010, 32'h00, 32'h01234567, 32'h0,        0, 0);
        add("lw02err", 0, 3'b010, 32'h02, 32'h0,        32'h0,        1, 0);
        add("sh01err", 1, 3'b001, 32'h01, 32'hFFFFFFFF, 32'h0,        1, 0);
        add("ld011err",0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 0);
        add("st100err",1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0,        1, 0);
        add("lhu01err",0, 3'b101, 32'h01, 32'h0,        32'h0,        1, 0);
        add("lw00",    0, 3'b010, 32'h00, 32'h0,        32'h01234567, 0, 1);
        add("lh02",    0, 3'b001, 32'h02, 32'h0,        32'h00000123, 0, 1);
        add("lb01",    0, 3'b000, 32'h01, 32'h0,        32'h00000045, 0, 1);
        add("lh00",    0, 3'b001, 32'h00, 32'h0,        32'h00004567, 0, 1);
        add("sb00",    1, 3'b000, 32'h00, 32'h000000FF, 32'h0,        0, 1);
        add("lb00",    0, 3'b000, 32'h00, 32'h0,        32'hFFFFFFFF, 0, 1);
        add("lw00b",   0, 3'b010, 32'h00, 32'h0,        32'h012345FF, 0, 1);
        add("swalias", 1, 3'b010, (32'h1 << (AW + 2)) + 32'h10, 32'hA5A5A5A5, 32'h0, 0, 0);
        add("lwalias", 0, 3'b010, 32'h10, 32'h0,        32'hA5A5A5A5, 0, 1);

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset ready", {31'h0, req_ready}, 32'h1);
        chk("reset valid", {31'h0, resp_valid}, 32'h0);
        chk("reset rdata", resp_rdata, 32'h0);
        chk("reset error", {31'h0, resp_error}, 32'h0);

        foreach (vecs[i]) do_req(vecs[i]);

        // Reset during the RMW cycle of SB 0x10 must abort and suppress the write.
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort ready", {31'h0, req_ready}, 32'h1);
        chk("abort rdata", resp_rdata, 32'h0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("abort no resp", seen, 0);
        v.name = "lwabort"; v.wr = 0; v.f3 = 3'b010; v.addr = 32'h10; v.wdata = 0;
        v.exp_rdata = 32'hA5A5A5A5; v.exp_err = 0; v.lat = 1;
        do_req(v);

        // A request held during RD_WAIT must be ignored.
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        tick();
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        chk("busy ready", {31'h0, req_ready}, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("busy resp valid", {31'h0, resp_valid}, 32'h1);
        chk("busy resp rdata", resp_rdata, 32'hA5A5A5A5);
        tick();
        v.name = "lwbusy";
        do_req(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
